line_serializer: RTL and testbench

Parametrised successor of the top-k front-end parser. Takes wide AXI-Stream lines (default 512 bits) carrying packed elements and emits them one element per beat (default 32 bits) into the top-k datapath. Each output beat carries an end-of-packet flag and a clear flag. Compared with the previous parser, it adds:

- per-element keep
- a separate tlast input
- back-to-back line acceptance with no bubble
- real backpressure from its output FIFO
- status counters

---
 rtl/line_serializer_pkg.sv | 23 ++
 rtl/axis_fifo_sync.sv | 59 +++++
 rtl/line_serializer.sv | 184 ++++++++++++++++++
 tb/tb_line_serializer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_serializer_pkg.sv
// Shared types and parameter helpers for the line serializer.
package line_serializer_pkg;

    // Serializer control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Elements carried by one input line
    function automatic int unsigned elems_per_line(input int unsigned line_w,
                                                   input int unsigned elem_w);
        return line_w / elem_w;
    endfunction

    // True when the line splits into a whole number (>= 2) of elements
    function automatic bit params_ok(input int unsigned line_w,
                                     input int unsigned elem_w);
        return (elem_w != 0) && ((line_w % elem_w) == 0) && ((line_w / elem_w) >= 2);
    endfunction

endpackage

// File: rtl/axis_fifo_sync.sv
// Single-clock first-word-fall-through FIFO; a write while full is refused
// even if a read happens in the same cycle.
module axis_fifo_sync #(
    parameter int unsigned DATA_W    = 34,
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 rd_en,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   count
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   cnt;
    logic                 wr_fire;
    logic                 rd_fire;

    assign full    = (cnt == (ADDR_BITS+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage, pointers and occupancy; reset clears everything so the head reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_fire) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + ADDR_BITS'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + ADDR_BITS'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   cnt <= cnt + (ADDR_BITS+1)'(1);
                2'b01:   cnt <= cnt - (ADDR_BITS+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/line_serializer.sv
// Splits wide AXI-Stream lines into one element per beat for the top-k datapath.
module line_serializer
    import line_serializer_pkg::*;
#(
    parameter int unsigned LINE_W         = 512,
    parameter int unsigned ELEM_W         = 32,
    parameter int unsigned FIFO_ADDR_BITS = 5,
    localparam int unsigned N             = elems_per_line(LINE_W, ELEM_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] s_axis_tdata,
    input  logic [N-1:0]      s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [ELEM_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tclear,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [31:0]       lines_in,
    output logic [31:0]       elems_out,
    output logic              err_empty_last
);

    localparam int unsigned FIFO_W = ELEM_W + 2;

    if (!params_ok(LINE_W, ELEM_W)) begin : g_param_check
        $error("line_serializer: LINE_W must be a multiple of ELEM_W giving at least 2 elements");
    end

    state_t              state_q;
    state_t              state_d;
    logic [LINE_W-1:0]   data_q;
    logic [N-1:0]        keep_q;
    logic                last_q;
    logic                rdy_en_q;

    logic                in_ready_c;
    logic                load_c;
    logic                shift_c;
    logic                wr_c;
    logic [FIFO_W-1:0]   wr_data_c;
    logic                err_set_c;
    logic                last_elem_c;
    logic                sentinel_c;

    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_ADDR_BITS:0] fifo_count;
    logic [FIFO_W-1:0]   fifo_rd_data;
    logic                unused_fifo_count;

    assign last_elem_c       = (keep_q == N'(1));
    assign sentinel_c        = (&s_axis_tdata) & (&s_axis_tkeep);
    assign s_axis_tready     = in_ready_c;
    assign unused_fifo_count = ^fifo_count;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, FIFO write and line-load decode
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        load_c     = 1'b0;
        shift_c    = 1'b0;
        wr_c       = 1'b0;
        wr_data_c  = '0;
        err_set_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready_c = rdy_en_q;
            end
            SHIFT: begin
                if (!fifo_full) begin
                    wr_c      = 1'b1;
                    shift_c   = 1'b1;
                    wr_data_c = {last_q & last_elem_c, 1'b0, data_q[ELEM_W-1:0]};
                    if (last_elem_c) begin
                        in_ready_c = rdy_en_q;
                        state_d    = IDLE;
                    end
                end
            end
            CLEAR: begin
                if (!fifo_full) begin
                    wr_c      = 1'b1;
                    wr_data_c = {1'b1, 1'b1, {ELEM_W{1'b1}}};
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A line taken in IDLE or on the final element of SHIFT is decoded the same way
        if (in_ready_c && s_axis_tvalid) begin
            load_c = 1'b1;
            if (sentinel_c) begin
                state_d = CLEAR;
            end else if (s_axis_tkeep == '0) begin
                state_d   = IDLE;
                err_set_c = s_axis_tlast;
            end else begin
                state_d = SHIFT;
            end
        end
    end

    // Input acceptance is held off until the first clock after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    // Shift register: load a new line or drop the element just written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else if (load_c) begin
            data_q <= s_axis_tdata;
            keep_q <= s_axis_tkeep;
            last_q <= s_axis_tlast;
        end else if (shift_c) begin
            data_q <= data_q >> ELEM_W;
            keep_q <= keep_q >> 1;
        end
    end

    // Status counters and sticky empty-last flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lines_in       <= '0;
            elems_out      <= '0;
            err_empty_last <= 1'b0;
        end else begin
            if (load_c) begin
                lines_in <= lines_in + 32'd1;
            end
            if (wr_c) begin
                elems_out <= elems_out + 32'd1;
            end
            if (err_set_c) begin
                err_empty_last <= 1'b1;
            end
        end
    end

    axis_fifo_sync #(
        .DATA_W    (FIFO_W),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_c),
        .wr_data (wr_data_c),
        .rd_en   (m_axis_tready),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign m_axis_tdata  = fifo_rd_data[ELEM_W-1:0];
    assign m_axis_tclear = fifo_rd_data[ELEM_W];
    assign m_axis_tlast  = fifo_rd_data[ELEM_W+1];
    assign m_axis_tvalid = ~fifo_empty;

endmodule

// File: tb/tb_line_serializer.sv
// Directed bench for line_serializer with default parameters.
module tb_line_serializer;

    localparam int unsigned LW = 512;
    localparam int unsigned EW = 32;
    localparam int unsigned N  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] s_data = '0;
    logic [N-1:0]  s_keep = '0;
    logic          s_last = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [EW-1:0] m_data;
    logic          m_last;
    logic          m_clear;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [31:0]   lines_in;
    logic [31:0]   elems_out;
    logic          err_empty_last;

    always #5 clk = ~clk;

    line_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_data),
        .s_axis_tkeep   (s_keep),
        .s_axis_tlast   (s_last),
        .s_axis_tvalid  (s_valid),
        .s_axis_tready  (s_ready),
        .m_axis_tdata   (m_data),
        .m_axis_tlast   (m_last),
        .m_axis_tclear  (m_clear),
        .m_axis_tvalid  (m_valid),
        .m_axis_tready  (m_ready),
        .lines_in       (lines_in),
        .elems_out      (elems_out),
        .err_empty_last (err_empty_last)
    );

    typedef struct {
        logic [EW-1:0] data;
        logic          last;
        logic          clear;
        int            cyc;
    } beat_t;

    beat_t q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errs = 0;

    // Collect every output handshake with its cycle number
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && m_valid && m_ready) begin
            q.push_back('{data: m_data, last: m_last, clear: m_clear, cyc: cyc});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] mk_line(input int base);
        logic [LW-1:0] d;
        d = '0;
        for (int i = 0; i < int'(N); i++) d[i*EW +: EW] = EW'(base + i);
        return d;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_keep = '0;
        s_last = 1'b0;
        s_data = '0;
        tick(2);
        rst = 1'b0;
        q.delete();
    endtask

    // Present a line and return just after the edge that accepted it
    task automatic send_line(input logic [LW-1:0] d, input logic [N-1:0] k, input logic l);
        bit rdy;
        bit done;
        s_data = d;
        s_keep = k;
        s_last = l;
        s_valid = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            rdy = s_ready;
            tick(1);
            if (rdy) done = 1'b1;
        end
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic idle_in();
        s_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string tag);
        for (int t = 0; t < 500 && q.size() < n; t++) tick(1);
        check(tag, q.size(), n);
    endtask

    int gaps;
    int nlast;

    initial begin
        // Reset state
        tick(2);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_clear", m_clear, 0);
        check("rst_lines", lines_in, 0);
        check("rst_elems", elems_out, 0);
        check("rst_err", err_empty_last, 0);
        rst = 1'b0;
        tick(1);
        check("rst_ready_after", s_ready, 1);

        // 1: single full packet with latency check
        do_reset();
        m_ready = 1'b1;
        send_line(mk_line(0), 16'hFFFF, 1'b1);
        idle_in();
        check("t1_lat_early", m_valid, 0);
        tick(1);
        check("t1_lat_valid", m_valid, 1);
        check("t1_lat_data", m_data, 0);
        wait_beats(16, "t1_count");
        tick(3);
        check("t1_no_extra", q.size(), 16);
        gaps = 0;
        for (int i = 0; i < q.size(); i++) begin
            check($sformatf("t1_data%0d", i), q[i].data, i);
            check($sformatf("t1_last%0d", i), q[i].last, (i == 15));
            if (q[i].clear) gaps++;
        end
        check("t1_no_clear", gaps, 0);
        check("t1_elems", elems_out, 16);
        check("t1_lines", lines_in, 1);

        // 2: back-to-back lines, second one partial
        do_reset();
        send_line(mk_line(100), 16'hFFFF, 1'b0);
        send_line(mk_line(200), 16'h000F, 1'b1);
        idle_in();
        wait_beats(20, "t2_count");
        tick(3);
        check("t2_no_extra", q.size(), 20);
        gaps = 0;
        nlast = 0;
        for (int i = 0; i < q.size(); i++) begin
            check($sformatf("t2_data%0d", i), q[i].data, (i < 16) ? 100 + i : 200 + i - 16);
            if (i > 0 && q[i].cyc != q[i-1].cyc + 1) gaps++;
            if (q[i].last) nlast++;
        end
        check("t2_contig", gaps, 0);
        check("t2_nlast", nlast, 1);
        if (q.size() == 20) check("t2_last19", q[19].last, 1);
        check("t2_lines", lines_in, 2);
        check("t2_elems", elems_out, 20);

        // 3: sentinel then a normal line
        do_reset();
        send_line({LW{1'b1}}, 16'hFFFF, 1'b0);
        idle_in();
        check("t3_ready_clear", s_ready, 0);
        wait_beats(1, "t3_count1");
        check("t3_s_data", q[0].data, 32'hFFFF_FFFF);
        check("t3_s_last", q[0].last, 1);
        check("t3_s_clear", q[0].clear, 1);
        send_line(mk_line(40), 16'h0003, 1'b1);
        idle_in();
        wait_beats(3, "t3_count3");
        tick(3);
        check("t3_no_extra", q.size(), 3);
        if (q.size() == 3) begin
            check("t3_d1", q[1].data, 40);
            check("t3_d2", q[2].data, 41);
            check("t3_l1", q[1].last, 0);
            check("t3_l2", q[2].last, 1);
            check("t3_c2", q[2].clear, 0);
        end
        check("t3_elems", elems_out, 3);
        check("t3_lines", lines_in, 2);

        // 4: backpressure fills the FIFO and stalls input
        do_reset();
        m_ready = 1'b0;
        for (int l = 0; l < 3; l++) send_line(mk_line(1000 + 16 * l), 16'hFFFF, (l == 2));
        idle_in();
        tick(5);
        check("t4_stall_ready", s_ready, 0);
        check("t4_valid", m_valid, 1);
        check("t4_head", m_data, 1000);
        check("t4_elems_full", elems_out, 32);
        check("t4_lines", lines_in, 3);
        check("t4_none_out", q.size(), 0);
        tick(3);
        check("t4_head_stable", m_data, 1000);
        m_ready = 1'b1;
        wait_beats(48, "t4_count");
        tick(3);
        check("t4_no_extra", q.size(), 48);
        for (int i = 0; i < q.size(); i++) begin
            check($sformatf("t4_data%0d", i), q[i].data, 1000 + i);
            check($sformatf("t4_last%0d", i), q[i].last, (i == 47));
        end
        check("t4_elems", elems_out, 48);

        // 5: empty line with tlast sets the sticky error
        do_reset();
        send_line(mk_line(7), 16'h0000, 1'b1);
        idle_in();
        tick(5);
        check("t5_no_beat", q.size(), 0);
        check("t5_err", err_empty_last, 1);
        check("t5_lines", lines_in, 1);
        check("t5_elems", elems_out, 0);
        send_line(mk_line(50), 16'h0001, 1'b1);
        idle_in();
        wait_beats(1, "t5_count");
        check("t5_data", q[0].data, 50);
        check("t5_last", q[0].last, 1);
        check("t5_err_sticky", err_empty_last, 1);
        check("t5_lines2", lines_in, 2);

        // 6: reset in the middle of a line
        do_reset();
        send_line(mk_line(500), 16'hFFFF, 1'b1);
        idle_in();
        wait_beats(5, "t6_five");
        #2 rst = 1'b1;
        #1;
        check("t6_valid", m_valid, 0);
        check("t6_lines", lines_in, 0);
        check("t6_elems", elems_out, 0);
        check("t6_ready", s_ready, 0);
        tick(1);
        rst = 1'b0;
        q.delete();
        send_line(mk_line(600), 16'h0003, 1'b1);
        idle_in();
        wait_beats(2, "t6_count");
        tick(3);
        check("t6_no_extra", q.size(), 2);
        if (q.size() == 2) begin
            check("t6_d0", q[0].data, 600);
            check("t6_d1", q[1].data, 601);
            check("t6_l1", q[1].last, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
